// File: rtl/simon_round_controller.sv
// Simon Says round sequencer: fills an arrow sequence from an LFSR, replays a growing prefix,
// then checks the player's presses. Optional SIMON_TIMEOUT_EN adds a WAIT_IN press timeout.
//
// Ports:
//   clock, resetn (async, active-low)
//   start, seed          - begin a new game, LFSR seed
//   btn_valid, btn_dir   - player press
//   show_valid, show_dir - arrow display
//   await_input          - waiting for presses
//   level                - current round length
//   win, lose            - game result flags
module simon_round_controller #(
    parameter int SEQ_LEN       = 4,
    parameter int STEP_TICKS    = 8,
    parameter int GAP_TICKS     = 2,
    parameter int TIMEOUT_TICKS = 64
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] seed,
    input  logic       btn_valid,
    input  logic [1:0] btn_dir,
    output logic       show_valid,
    output logic [1:0] show_dir,
    output logic       await_input,
    output logic [3:0] level,
    output logic       win,
    output logic       lose
);

    localparam int IW   = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int M1   = (STEP_TICKS > GAP_TICKS) ? STEP_TICKS : GAP_TICKS;
    localparam int MAXT = (M1 > TIMEOUT_TICKS) ? M1 : TIMEOUT_TICKS;
    localparam int TW   = $clog2(MAXT + 1);

    localparam logic [TW-1:0] STEP_LAST = TW'(STEP_TICKS - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_TICKS - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(SEQ_LEN - 1);
    localparam logic [3:0]    LVL_MAX   = 4'(SEQ_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHOW_ON,
        S_SHOW_GAP,
        S_WAIT_IN,
        S_WIN,
        S_LOSE
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      lfsr_q;
    logic [7:0]      lfsr_nxt;
    logic [1:0]      seq_q [SEQ_LEN];
    logic [IW-1:0]   idx_q;
    logic [3:0]      level_q;
    logic [TW-1:0]   tick_q;
    logic [1:0]      cur_dir;
    logic            last_idx;
    logic            hit;
    logic            idle_grp;
    logic            tmo_hit;

    assign lfsr_nxt = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign cur_dir  = seq_q[idx_q];
    assign last_idx = (4'(idx_q) == (level_q - 4'd1));
    assign hit      = (btn_dir == cur_dir);
    assign idle_grp = (state_q == S_IDLE) || (state_q == S_WIN) || (state_q == S_LOSE);

`ifdef SIMON_TIMEOUT_EN
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_TICKS - 1);
    assign tmo_hit = (tick_q == TMO_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_WIN, S_LOSE: if (start) state_d = S_LOAD;
            S_LOAD:     if (idx_q == IDX_LAST) state_d = S_SHOW_ON;
            S_SHOW_ON:  if (tick_q == STEP_LAST) state_d = S_SHOW_GAP;
            S_SHOW_GAP: begin
                if (tick_q == GAP_LAST)
                    state_d = last_idx ? S_WAIT_IN : S_SHOW_ON;
            end
            S_WAIT_IN: begin
                if (btn_valid) begin
                    if (!hit)
                        state_d = S_LOSE;
                    else if (last_idx)
                        state_d = (level_q == LVL_MAX) ? S_WIN : S_SHOW_ON;
                end else if (tmo_hit) begin
                    state_d = S_LOSE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            lfsr_q  <= 8'h01;
            idx_q   <= '0;
            level_q <= 4'd0;
            tick_q  <= '0;
            for (int i = 0; i < SEQ_LEN; i++) seq_q[i] <= 2'b00;
        end else begin
            state_q <= state_d;
            if (idle_grp) begin
                if (start) begin
                    lfsr_q  <= (seed == 8'h00) ? 8'h01 : seed;
                    level_q <= 4'd1;
                    idx_q   <= '0;
                    tick_q  <= '0;
                end
            end else begin
                unique case (state_q)
                    S_LOAD: begin
                        seq_q[idx_q] <= lfsr_q[1:0];
                        lfsr_q       <= lfsr_nxt;
                        idx_q        <= (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
                    end
                    S_SHOW_ON: begin
                        tick_q <= (tick_q == STEP_LAST) ? '0 : tick_q + TW'(1);
                    end
                    S_SHOW_GAP: begin
                        if (tick_q == GAP_LAST) begin
                            tick_q <= '0;
                            idx_q  <= last_idx ? '0 : idx_q + IW'(1);
                        end else begin
                            tick_q <= tick_q + TW'(1);
                        end
                    end
                    S_WAIT_IN: begin
                        if (btn_valid) begin
                            tick_q <= '0;
                            if (hit) begin
                                if (!last_idx) begin
                                    idx_q <= idx_q + IW'(1);
                                end else if (level_q != LVL_MAX) begin
                                    level_q <= level_q + 4'd1;
                                    idx_q   <= '0;
                                end
                            end
                        end else begin
`ifdef SIMON_TIMEOUT_EN
                            tick_q <= tick_q + TW'(1);
`else
                            tick_q <= '0;
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign show_valid  = (state_q == S_SHOW_ON);
    assign show_dir    = show_valid ? cur_dir : 2'b00;
    assign await_input = (state_q == S_WAIT_IN);
    assign level       = level_q;
    assign win         = (state_q == S_WIN);
    assign lose        = (state_q == S_LOSE);

endmodule

// File: tb/tb_simon_round_controller.sv
// Directed testbench for simon_round_controller (default parameters).
// Seed 8'hB4 yields the arrow sequence 00,01,10,00; seed 8'h00 acts as 8'h01 (first arrow 01).
module tb_simon_round_controller;

    logic       clock = 1'b0;
    logic       resetn;
    logic       start;
    logic [7:0] seed;
    logic       btn_valid;
    logic [1:0] btn_dir;
    logic       show_valid;
    logic [1:0] show_dir;
    logic       await_input;
    logic [3:0] level;
    logic       win;
    logic       lose;

    int checks = 0;
    int errors = 0;

    simon_round_controller dut (
        .clock(clock),
        .resetn(resetn),
        .start(start),
        .seed(seed),
        .btn_valid(btn_valid),
        .btn_dir(btn_dir),
        .show_valid(show_valid),
        .show_dir(show_dir),
        .await_input(await_input),
        .level(level),
        .win(win),
        .lose(lose)
    );

    always #5 clock = ~clock;

    task automatic pulse_start(input logic [7:0] s);
        start = 1'b1;
        seed  = s;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic press(input logic [1:0] d);
        btn_valid = 1'b1;
        btn_dir   = d;
        @(negedge clock);
        btn_valid = 1'b0;
    endtask

    // Waits for await_input, recording each arrow shown on show_valid rising.
    task automatic wait_await(input int bound, output logic ok,
                              output logic [15:0] dirs, output int n);
        logic prev;
        prev = 1'b0;
        n    = 0;
        dirs = '0;
        for (int i = 0; i < bound && !await_input; i++) begin
            if (show_valid && !prev && n < 8) begin
                dirs[2*n +: 2] = show_dir;
                n++;
            end
            prev = show_valid;
            @(negedge clock);
        end
        ok = await_input;
    endtask

    task automatic test_reset;
        resetn    = 1'b0;
        start     = 1'b0;
        seed      = 8'h00;
        btn_valid = 1'b0;
        btn_dir   = 2'b00;
        repeat (2) @(negedge clock);
        checks++;
        if ({show_valid, show_dir, await_input, level, win, lose} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outs got %b want 0",
                     {show_valid, show_dir, await_input, level, win, lose});
        end
        resetn = 1'b1;
        @(negedge clock);
        checks++;
        if ({show_valid, show_dir, await_input, level, win, lose} !== 10'd0) begin
            errors++;
            $display("FAIL idle_outs got %b want 0",
                     {show_valid, show_dir, await_input, level, win, lose});
        end
    endtask

    task automatic test_load_show;
        int bad;
        pulse_start(8'hB4);
        checks++;
        if (show_valid !== 1'b0 || level !== 4'd1) begin
            errors++;
            $display("FAIL load_first got sv=%b lvl=%0d want sv=0 lvl=1", show_valid, level);
        end
        repeat (4) @(negedge clock);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (show_valid !== 1'b1 || show_dir !== 2'b00) bad++;
            @(negedge clock);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL show_on_r1 got %0d bad cycles want 0", bad);
        end
        bad = 0;
        for (int i = 0; i < 2; i++) begin
            if (show_valid !== 1'b0 || show_dir !== 2'b00 || await_input !== 1'b0) bad++;
            @(negedge clock);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL gap_r1 got %0d bad cycles want 0", bad);
        end
        checks++;
        if (await_input !== 1'b1 || level !== 4'd1) begin
            errors++;
            $display("FAIL await_r1 got aw=%b lvl=%0d want aw=1 lvl=1", await_input, level);
        end
    endtask

    task automatic test_win;
        logic ok;
        logic [15:0] dirs;
        int n;
        press(2'b00);
        wait_await(200, ok, dirs, n);
        checks++;
        if (!ok || level !== 4'd2 || n != 2 || dirs[3:0] !== 4'b0100) begin
            errors++;
            $display("FAIL round2 got ok=%b lvl=%0d n=%0d dirs=%b want 1 2 2 0100",
                     ok, level, n, dirs[3:0]);
        end
        press(2'b00);
        checks++;
        if (await_input !== 1'b1 || level !== 4'd2) begin
            errors++;
            $display("FAIL mid_press got aw=%b lvl=%0d want aw=1 lvl=2", await_input, level);
        end
        press(2'b01);
        wait_await(200, ok, dirs, n);
        checks++;
        if (!ok || level !== 4'd3 || n != 3 || dirs[5:0] !== 6'b100100) begin
            errors++;
            $display("FAIL round3 got ok=%b lvl=%0d n=%0d dirs=%b want 1 3 3 100100",
                     ok, level, n, dirs[5:0]);
        end
        press(2'b00);
        press(2'b01);
        press(2'b10);
        wait_await(200, ok, dirs, n);
        checks++;
        if (!ok || level !== 4'd4 || n != 4 || dirs[7:0] !== 8'b00100100) begin
            errors++;
            $display("FAIL round4 got ok=%b lvl=%0d n=%0d dirs=%b want 1 4 4 00100100",
                     ok, level, n, dirs[7:0]);
        end
        press(2'b00);
        press(2'b01);
        press(2'b10);
        press(2'b00);
        checks++;
        if (win !== 1'b1 || lose !== 1'b0 || level !== 4'd4 || await_input !== 1'b0) begin
            errors++;
            $display("FAIL win got w=%b l=%b lvl=%0d aw=%b want 1 0 4 0",
                     win, lose, level, await_input);
        end
        repeat (5) @(negedge clock);
        checks++;
        if (win !== 1'b1 || level !== 4'd4) begin
            errors++;
            $display("FAIL win_hold got w=%b lvl=%0d want 1 4", win, level);
        end
    endtask

    task automatic test_lose;
        logic ok;
        logic [15:0] dirs;
        int n;
        pulse_start(8'hB4);
        checks++;
        if (win !== 1'b0 || level !== 4'd1) begin
            errors++;
            $display("FAIL restart got w=%b lvl=%0d want 0 1", win, level);
        end
        wait_await(200, ok, dirs, n);
        press(2'b00);
        wait_await(200, ok, dirs, n);
        press(2'b00);
        press(2'b11);
        checks++;
        if (lose !== 1'b1 || win !== 1'b0 || level !== 4'd2 || show_valid !== 1'b0) begin
            errors++;
            $display("FAIL lose got l=%b w=%b lvl=%0d sv=%b want 1 0 2 0",
                     lose, win, level, show_valid);
        end
    endtask

    task automatic test_start_and_press;
        logic ok;
        logic [15:0] dirs;
        int n;
        pulse_start(8'hB4);
        wait_await(200, ok, dirs, n);
        start     = 1'b1;
        seed      = 8'h00;
        btn_valid = 1'b1;
        btn_dir   = 2'b00;
        @(negedge clock);
        start     = 1'b0;
        btn_valid = 1'b0;
        checks++;
        if (level !== 4'd2 || show_valid !== 1'b1 || show_dir !== 2'b00) begin
            errors++;
            $display("FAIL start_with_press got lvl=%0d sv=%b dir=%b want 2 1 00",
                     level, show_valid, show_dir);
        end
    endtask

    task automatic test_reset_mid;
        logic ok;
        logic [15:0] dirs;
        int n;
        wait_await(200, ok, dirs, n);
        press(2'b00);
        press(2'b01);
        repeat (3) @(negedge clock);
        checks++;
        if (show_valid !== 1'b1 || level !== 4'd3) begin
            errors++;
            $display("FAIL pre_reset got sv=%b lvl=%0d want 1 3", show_valid, level);
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (show_valid !== 1'b0 || level !== 4'd0 || await_input !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got sv=%b lvl=%0d aw=%b want 0 0 0",
                     show_valid, level, await_input);
        end
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_seed_zero;
        pulse_start(8'h00);
        repeat (4) @(negedge clock);
        checks++;
        if (show_valid !== 1'b1 || show_dir !== 2'b01 || level !== 4'd1) begin
            errors++;
            $display("FAIL seed_zero got sv=%b dir=%b lvl=%0d want 1 01 1",
                     show_valid, show_dir, level);
        end
        press(2'b11);
        checks++;
        if (lose !== 1'b0 || show_valid !== 1'b1) begin
            errors++;
            $display("FAIL btn_in_show got l=%b sv=%b want 0 1", lose, show_valid);
        end
    endtask

    task automatic test_no_timeout;
        logic ok;
        logic [15:0] dirs;
        int n;
        wait_await(200, ok, dirs, n);
        checks++;
        if (!ok || level !== 4'd1 || lose !== 1'b0) begin
            errors++;
            $display("FAIL await_seed0 got ok=%b lvl=%0d l=%b want 1 1 0", ok, level, lose);
        end
`ifdef SIMON_TIMEOUT_EN
        repeat (63) @(negedge clock);
        checks++;
        if (lose !== 1'b0 || await_input !== 1'b1) begin
            errors++;
            $display("FAIL tmo_early got l=%b aw=%b want 0 1", lose, await_input);
        end
        @(negedge clock);
        checks++;
        if (lose !== 1'b1) begin
            errors++;
            $display("FAIL tmo_lose got l=%b want 1", lose);
        end
`else
        repeat (1000) @(negedge clock);
        checks++;
        if (await_input !== 1'b1 || lose !== 1'b0 || level !== 4'd1) begin
            errors++;
            $display("FAIL no_timeout got aw=%b l=%b lvl=%0d want 1 0 1",
                     await_input, lose, level);
        end
        press(2'b01);
        checks++;
        if (level !== 4'd2 || show_valid !== 1'b1) begin
            errors++;
            $display("FAIL late_press got lvl=%0d sv=%b want 2 1", level, show_valid);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_load_show();
        test_win();
        test_lose();
        test_start_and_press();
        test_reset_mid();
        test_seed_zero();
        test_no_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
